// File: rtl/pack2_to_byte.sv
// Purpose : packs consecutive 2-bit words from the registered mux into one W=2*WORDS bit word.
// Latency : 1 cycle from the last accepted input word to valid_out; no bubble when back-to-back.
// Backpr. : one-deep output register; ready_in drops only while an output is pending AND the
//           accumulator needs just its final word. Offers made while ready_in=0 are dropped
//           and latch the sticky overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   reset_L    synchronous active-low reset
//   valid_in   data_in carries a word this cycle
//   data_in    2-bit input word
//   ready_in   block can accept a word this cycle (registered-state only)
//   data_out   completed packed word
//   valid_out  data_out holds a completed, unconsumed word
//   ready_out  consumer takes data_out this cycle
//   count_out  words currently held in the accumulator (0..WORDS-1)
//   overflow   sticky; a word was offered while ready_in=0
module pack2_to_byte #(
  parameter int WORDS     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       valid_in,
  input  logic [1:0]                 data_in,
  output logic                       ready_in,
  output logic [2*WORDS-1:0]         data_out,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [$clog2(WORDS)-1:0]   count_out,
  output logic                       overflow
);

  localparam int W  = 2 * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  // The output register state is exactly valid_out.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  out_state_e    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          last_slot;
  logic          accept;
  logic          complete;
  logic          xfer;
  int            shamt;
  logic [W-1:0]  full_word;

  assign last_slot = (cnt_q == LAST);
  assign valid_out = (state_q == OUT_FULL);
  // Only the final word of a packed word needs the output register to be free;
  // earlier words keep accumulating while an output is still pending.
  assign ready_in  = !(valid_out && last_slot);
  assign accept    = valid_in && ready_in;
  assign complete  = accept && last_slot;
  assign xfer      = valid_out && ready_out;

  // Slot placement: the accumulator is cleared at every completion and each
  // slot is written once, so ORing the shifted word in is sufficient.
  always_comb begin
    shamt = 0;
    if (LSB_FIRST) begin
      shamt = 2 * int'(cnt_q);
    end else begin
      shamt = W - 2 - 2 * int'(cnt_q);
    end
    full_word = acc_q | (W'(data_in) << shamt);
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    state_d = state_q;

    if (accept) begin
      if (last_slot) begin
        acc_d  = '0;
        cnt_d  = '0;
        dout_d = full_word;
      end else begin
        acc_d  = full_word;
        cnt_d  = cnt_q + 1'b1;
      end
    end

    if (valid_in && !ready_in) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        // A transfer coinciding with a completion keeps the register full
        // (data_out reloads), giving back-to-back words with no bubble.
        if (xfer && !complete) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= OUT_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out  = dout_q;
  assign count_out = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pack2_to_byte.sv
// Bench for pack2_to_byte: two instances (LSB-first and MSB-first) share all inputs.
// A queue-based model predicts every registered output after each clock edge.
module tb_pack2_to_byte;

  localparam int WORDS = 4;
  localparam int W     = 2 * WORDS;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_L;
  logic         valid_in;
  logic [1:0]   data_in;
  logic         ready_out;

  logic         ready_in,  valid_out,  overflow;
  logic [W-1:0] data_out;
  logic [1:0]   count_out;
  logic         ready_in_m, valid_out_m, overflow_m;
  logic [W-1:0] data_out_m;
  logic [1:0]   count_out_m;

  pack2_to_byte #(.WORDS(WORDS), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .count_out(count_out), .overflow(overflow)
  );

  pack2_to_byte #(.WORDS(WORDS), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in_m), .data_out(data_out_m), .valid_out(valid_out_m),
    .ready_out(ready_out), .count_out(count_out_m), .overflow(overflow_m)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of accepted words of the current packed word,
  // pending flag of the output register, last completed words, sticky flag.
  logic [1:0]   m_acc[$];
  bit           m_pend = 1'b0;
  bit           m_ovf  = 1'b0;
  logic [W-1:0] m_dl   = '0;
  logic [W-1:0] m_dm   = '0;
  bit           xfer_seen;
  int           xfers;

  function automatic bit m_rdy();
    return !(m_pend && m_acc.size() == WORDS - 1);
  endfunction

  function automatic void model_step();
    bit           rdy;
    logic [W-1:0] bl, bm;
    if (!reset_L) begin
      m_acc.delete();
      m_pend = 1'b0;
      m_ovf  = 1'b0;
      m_dl   = '0;
      m_dm   = '0;
      return;
    end
    rdy = m_rdy();
    if (valid_in && !rdy) m_ovf = 1'b1;
    if (m_pend && ready_out) m_pend = 1'b0;
    if (valid_in && rdy) begin
      m_acc.push_back(data_in);
      if (m_acc.size() == WORDS) begin
        bl = '0;
        bm = '0;
        for (int k = 0; k < WORDS; k++) begin
          bl = bl | (W'(m_acc[k]) << (2 * k));
          bm = bm | (W'(m_acc[k]) << (2 * (WORDS - 1 - k)));
        end
        m_dl   = bl;
        m_dm   = bm;
        m_pend = 1'b1;
        m_acc.delete();
      end
    end
  endfunction

  // Applies inputs, advances the model, then waits until just after the edge.
  task automatic drive(input logic rl, input logic v, input logic [1:0] d, input logic r);
    reset_L   = rl;
    valid_in  = v;
    data_in   = d;
    ready_out = r;
    model_step();
    xfer_seen = valid_out && ready_out && reset_L;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 2'b11, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 1'b0);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    n_checks++; if (data_out_m !== 8'h00) begin n_fail++; $display("FAIL reset_data_out_m: got %h expected 00", data_out_m); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    n_checks++; if (count_out !== 2'd0) begin n_fail++; $display("FAIL reset_count_out: got %0d expected 0", count_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
  endtask

  task automatic test_basic();
    logic [1:0] w[4]   = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [1:0] exp[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    drive(1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, w[i], 1'b1);
      n_checks++; if (count_out !== exp[i]) begin n_fail++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, count_out, exp[i]); end
      n_checks++; if (valid_out !== (i == 3)) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b expected %b", i, valid_out, (i == 3)); end
    end
    n_checks++; if (data_out !== 8'h39) begin n_fail++; $display("FAIL basic_data_out: got %h expected 39", data_out); end
    drive(1'b1, 1'b0, 2'b00, 1'b1);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle: got %b expected 0", valid_out); end
  endtask

  task automatic test_order();
    logic [1:0] w[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, w[i], 1'b1);
    n_checks++; if (valid_out_m !== 1'b1) begin n_fail++; $display("FAIL order_valid_m: got %b expected 1", valid_out_m); end
    n_checks++; if (data_out_m !== 8'h6C) begin n_fail++; $display("FAIL order_data_out_m: got %h expected 6c", data_out_m); end
    drive(1'b1, 1'b0, 2'b00, 1'b1);
  endtask

  logic [W-1:0] first_byte;

  task automatic test_backpressure();
    logic [1:0] d;
    for (int i = 0; i < 7; i++) begin
      d = 2'($urandom_range(0, 3));
      drive(1'b1, 1'b1, d, 1'b0);
      if (i == 3) first_byte = m_dl;
      if (i >= 3) begin
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, valid_out); end
        n_checks++; if (data_out !== first_byte) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h expected %h", i, data_out, first_byte); end
      end
    end
    n_checks++; if (ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_ready_in: got %b expected 0", ready_in); end
    n_checks++; if (count_out !== 2'd3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", count_out); end
  endtask

  task automatic test_overflow();
    logic [1:0] d;
    drive(1'b1, 1'b1, 2'b10, 1'b0);
    n_checks++; if (count_out !== 2'd3) begin n_fail++; $display("FAIL ovf_count: got %0d expected 3", count_out); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_checks++; if (data_out !== first_byte) begin n_fail++; $display("FAIL ovf_data_held: got %h expected %h", data_out, first_byte); end
    drive(1'b1, 1'b0, 2'b00, 1'b1);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL ovf_release_valid: got %b expected 0", valid_out); end
    n_checks++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL ovf_release_ready: got %b expected 1", ready_in); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    d = 2'($urandom_range(0, 3));
    drive(1'b1, 1'b1, d, 1'b0);
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b expected 1", valid_out); end
    n_checks++; if (data_out !== m_dl) begin n_fail++; $display("FAIL bp_second_byte: got %h expected %h", data_out, m_dl); end
    n_checks++; if (data_out_m !== m_dm) begin n_fail++; $display("FAIL bp_second_byte_m: got %h expected %h", data_out_m, m_dm); end
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] d;
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    xfers = 0;
    for (int i = 0; i < 12; i++) begin
      d = 2'($urandom_range(0, 3));
      drive(1'b1, 1'b1, d, 1'b1);
      if (xfer_seen) xfers++;
      n_checks++; if (valid_out !== m_pend) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, valid_out, m_pend); end
      if (m_pend) begin
        n_checks++; if (data_out !== m_dl) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, data_out, m_dl); end
      end
    end
    drive(1'b1, 1'b0, 2'b00, 1'b1);
    if (xfer_seen) xfers++;
    n_checks++; if (xfers !== 3) begin n_fail++; $display("FAIL b2b_transfers: got %0d expected 3", xfers); end
  endtask

  task automatic test_reset_mid();
    logic [1:0]   w[4];
    logic [W-1:0] expb;
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    n_checks++; if (count_out !== 2'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", count_out); end
    expb = '0;
    for (int i = 0; i < 4; i++) begin
      w[i] = 2'($urandom_range(0, 3));
      expb = expb + W'(w[i]) * W'(1 << (2 * i));
      drive(1'b1, 1'b1, w[i], 1'b0);
    end
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b expected 1", valid_out); end
    n_checks++; if (data_out !== expb) begin n_fail++; $display("FAIL mid_data: got %h expected %h", data_out, expb); end
  endtask

  task automatic test_random();
    logic rl, v, r;
    logic [1:0] d;
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rl = ($urandom_range(0, 99) != 0);
      v  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 1) == 1);
      d  = 2'($urandom_range(0, 3));
      drive(rl, v, d, r);
      n_checks++; if (ready_in !== m_rdy()) begin n_fail++; $display("FAIL rnd_ready_in[%0d]: got %b expected %b", i, ready_in, m_rdy()); end
      n_checks++; if (valid_out !== m_pend) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, valid_out, m_pend); end
      n_checks++; if (count_out !== 2'(m_acc.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count_out, m_acc.size()); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", i, overflow, m_ovf); end
      if (m_pend) begin
        n_checks++; if (data_out !== m_dl) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, data_out, m_dl); end
        n_checks++; if (data_out_m !== m_dm) begin n_fail++; $display("FAIL rnd_data_m[%0d]: got %h expected %h", i, data_out_m, m_dm); end
      end
    end
  endtask

  initial begin
    reset_L   = 1'b0;
    valid_in  = 1'b0;
    data_in   = 2'b00;
    ready_out = 1'b0;
    test_reset();
    test_basic();
    test_order();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pack2_to_byte.md
Name: pack2_to_byte

Overview:
Downstream stage for the 2-bit registered 2:1 multiplexer. It collects consecutive 2-bit words from the mux output into one wide output word (8 bits by default). It presents each completed word on a valid/ready handshake to the next consumer. A one-deep output holding register lets accumulation continue while a completed word waits. Back-pressure is signalled upstream through ready_in.

Parameters:
WORDS, 4, number of 2-bit input words per output word; legal range 2..16; output width W = 2*WORDS.
LSB_FIRST, 1, 1: first accepted word lands in bits [1:0]; 0: first accepted word lands in bits [W-1:W-2].

Ports:
clk  input  1  single rising-edge clock.
reset_L  input  1  synchronous, active-low reset, sampled on posedge clk.
valid_in  input  1  data_in carries a valid 2-bit word this cycle.
data_in  input  2  2-bit word from the mux data_out.
ready_in  output  1  block can accept a word this cycle.
data_out  output  W  completed packed word.
valid_out  output  1  data_out holds a completed, unconsumed word.
ready_out  input  1  consumer accepts data_out this cycle.
count_out  output  clog2(WORDS)  words currently held in the accumulator (0..WORDS-1).
overflow  output  1  sticky; set when a word is offered while ready_in=0.

Behaviour:
- Reset (reset_L=0 at posedge clk) has priority over all other events. It sets:
  - accumulator=0, count_out=0
  - data_out=0, valid_out=0
  - overflow=0
  - ready_in=1 from the following cycle onward.
  - Any partial word or pending output is discarded, including on reset mid-operation.
- Accept condition: valid_in && ready_in at posedge clk.
- On accept with count<WORDS-1:
  - Word is written into slot count (LSB_FIRST=1: slot k = bits [2k+1:2k]; LSB_FIRST=0: slot k = bits [W-1-2k:W-2-2k]).
  - count increments by 1.
- On accept with count==WORDS-1 (completion):
  - Full word (accumulator plus current data_in in the last slot) loads data_out.
  - valid_out=1 the next cycle.
  - count wraps to 0 and accumulator clears.
  - Latency: last input word to valid_out = 1 cycle.
- Output handshake:
  - Transfer occurs when valid_out && ready_out at posedge clk.
  - valid_out clears the next cycle unless a completion occurs in the same cycle; in that case data_out reloads and valid_out stays 1 (back-to-back, no bubble).
  - data_out and valid_out are stable while valid_out && !ready_out.
- ready_in = !(valid_out && count==WORDS-1).
  - Depends on registered state only; there is no combinational path from ready_out or valid_in.
  - Words 0..WORDS-2 of the next output word are still accepted while an output is pending.
- Rejected offer (valid_in && !ready_in):
  - Word is dropped and state is unchanged.
  - overflow is set to 1 and holds until reset.
- valid_in=0: accumulator and count hold. There is no timeout and no flush.
- data_in is ignored (don't-care) when valid_in=0.
- Two internal states, derived from valid_out:
  - OUT_EMPTY -> OUT_FULL on completion.
  - OUT_FULL -> OUT_EMPTY on transfer without completion.
  - OUT_FULL -> OUT_FULL on transfer with completion, or on no transfer.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with valid_in=1 and data_in=2'b11 -> data_out=0, valid_out=0, count_out=0, overflow=0, ready_in=1.
- Basic pack, WORDS=4, LSB_FIRST=1, ready_out=1: feed 2'b01, 2'b10, 2'b11, 2'b00 on 4 consecutive cycles -> data_out=8'h39 and valid_out=1 for exactly 1 cycle, 1 cycle after the 4th word; count_out sequence 1,2,3,0.
- Order, LSB_FIRST=0: same 4 words -> data_out=8'h6C.
- Back-pressure: ready_out=0, feed 8 consecutive words -> first byte held stable; ready_in=0 after the 7th word accepted (count=3); raise ready_out -> first byte transfers, the 8th word is accepted the following cycle, and the second byte appears 1 cycle later.
- Overflow: in the stalled state above, assert valid_in with data_in=2'b10 -> word dropped, count_out stays 3, overflow=1 and remains 1 after ready_out releases; reset clears it.
- Back-to-back: ready_out=1, continuous valid_in over 12 words -> 3 bytes; valid_out stays high only on completion cycles; completion and transfer coinciding produce no bubble or lost byte.
- Reset mid-word: accept 2 words, pulse reset_L=0 for 1 cycle, then feed 4 words -> output contains only the 4 post-reset words.
